// File: rtl/seqdet_ctrl.sv
// Session controller for the serial sequence detector: programmable pattern,
// overlap mode, bounded sessions by bit window and/or match limit.
//
// state | meaning
// IDLE  | waiting for start, config writable
// ARM   | one cycle, clears history, fill and counters
// RUN   | consuming valid bits, detecting matches
// DONE  | session ended by window or match limit, config writable
module seqdet_ctrl #(
    parameter int PAT_LEN = 7,
    parameter int CNT_W   = 8,
    parameter int WIN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    input  logic [WIN_W-1:0]   cfg_win,
    input  logic [CNT_W-1:0]   cfg_max,
    input  logic               start,
    input  logic               abort,
    input  logic               ip,
    input  logic               ip_valid,
    output logic               op,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [WIN_W-1:0]   bit_cnt,
    output logic               err
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

    localparam int          FILL_W  = $clog2(PAT_LEN + 1);
    localparam logic [31:0] PAT_RST = 32'h0000_0053;

    state_t state, state_nxt;

    logic [PAT_LEN-1:0] pattern;
    logic               overlap;
    logic [WIN_W-1:0]   win;
    logic [CNT_W-1:0]   max_cnt;

    logic [PAT_LEN-2:0] hist;
    logic [FILL_W-1:0]  fill;

    logic [PAT_LEN-1:0] window;
    logic [FILL_W-1:0]  fill_inc;
    logic [CNT_W-1:0]   match_nxt;
    logic [WIN_W-1:0]   bit_nxt;
    logic               take, full, hit, at_win, at_max, finish, cfg_ok;

    // Newest bit sits at the LSB, so the window lines up with the pattern MSB-first.
    assign window    = {hist, ip};
    assign take      = (state == S_RUN) && ip_valid && !abort;
    assign full      = fill >= FILL_W'(PAT_LEN - 1);
    assign hit       = take && full && (window == pattern);
    assign bit_nxt   = bit_cnt + 1'b1;
    assign match_nxt = (hit && !(&match_cnt)) ? match_cnt + 1'b1 : match_cnt;
    assign at_win    = (win != '0) && (bit_nxt == win);
    assign at_max    = hit && (max_cnt != '0) && (match_nxt == max_cnt);
    assign finish    = take && (at_win || at_max);
    assign fill_inc  = full ? FILL_W'(PAT_LEN) : fill + 1'b1;
    assign cfg_ok    = (state == S_IDLE) || (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_ARM;
            S_ARM:   state_nxt = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort)       state_nxt = S_IDLE;
                else if (finish) state_nxt = S_DONE;
            end
            S_DONE:  if (start) state_nxt = S_ARM;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_ARM) || (state == S_RUN);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pattern   <= PAT_RST[PAT_LEN-1:0];
            overlap   <= 1'b1;
            win       <= '0;
            max_cnt   <= '0;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            bit_cnt   <= '0;
            op        <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (cfg_we && cfg_ok) begin
                pattern <= cfg_pattern;
                overlap <= cfg_overlap;
                win     <= cfg_win;
                max_cnt <= cfg_max;
            end
            if ((cfg_we || start) && busy) begin
                err <= 1'b1;
            end
            op <= hit;
            if ((state == S_ARM) && !abort) begin
                hist      <= '0;
                fill      <= '0;
                match_cnt <= '0;
                bit_cnt   <= '0;
            end else if (take) begin
                hist      <= window[PAT_LEN-2:0];
                bit_cnt   <= bit_nxt;
                match_cnt <= match_nxt;
                // Non-overlapping mode demands PAT_LEN fresh bits after each match.
                fill      <= (hit && !overlap) ? '0 : fill_inc;
            end
        end
    end

endmodule

// File: tb/tb_seqdet_ctrl.sv
// Scoreboard bench for seqdet_ctrl: a bit-list reference model predicts match
// positions and session end; a negedge monitor pairs each op pulse with them.
module tb_seqdet_ctrl;

    localparam int L = 7;
    localparam logic [L-1:0] PAT_DEF = 7'b1010011;

    logic          clk = 1'b0;
    logic          rst, cfg_we, cfg_overlap, start, abort, ip, ip_valid;
    logic [L-1:0]  cfg_pattern;
    logic [15:0]   cfg_win;
    logic [7:0]    cfg_max;
    logic          op, busy, done, err;
    logic [7:0]    match_cnt;
    logic [15:0]   bit_cnt;

    always #5 clk = ~clk;

    seqdet_ctrl #(.PAT_LEN(L), .CNT_W(8), .WIN_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .cfg_win(cfg_win), .cfg_max(cfg_max),
        .start(start), .abort(abort), .ip(ip), .ip_valid(ip_valid),
        .op(op), .busy(busy), .done(done), .match_cnt(match_cnt),
        .bit_cnt(bit_cnt), .err(err)
    );

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int mon_e;

    logic [L-1:0] m_pat;
    bit           m_ovl;
    int           m_win, m_max;
    int           m_bits[$];
    int           m_since, m_bitn, m_mcnt;
    bit           m_active, m_busy, m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (op === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL op_unexpected: actual op=1 at bit_cnt=%0d required no pulse", bit_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                check("op_bitpos", {16'd0, bit_cnt}, mon_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [L-1:0] p, input bit o, input int w, input int mx);
        cfg_pattern = p;
        cfg_overlap = o;
        cfg_win     = w[15:0];
        cfg_max     = mx[7:0];
        cfg_we      = 1'b1;
        if (!m_busy) begin
            m_pat = p;
            m_ovl = o;
            m_win = w;
            m_max = mx;
        end
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_bits.delete();
        m_since  = 0;
        m_bitn   = 0;
        m_mcnt   = 0;
        m_active = 1;
        m_busy   = 1;
        m_done   = 0;
        tick();
    endtask

    task automatic feed_bit(input bit b, input bit v);
        bit hit;
        ip       = b;
        ip_valid = v;
        if (v && m_active) begin
            m_bits.push_back(b);
            m_since++;
            m_bitn++;
            hit = 0;
            if (m_since >= L) begin
                hit = 1;
                for (int i = 0; i < L; i++)
                    if (m_bits[m_bits.size() - 1 - i] != int'(m_pat[i])) hit = 0;
            end
            if (hit) begin
                if (m_mcnt < 255) m_mcnt++;
                exp_q.push_back(m_bitn & 16'hffff);
                if (!m_ovl) m_since = 0;
            end
            if ((m_win != 0 && m_bitn == m_win) || (hit && m_max != 0 && m_mcnt == m_max)) begin
                m_active = 0;
                m_busy   = 0;
                m_done   = 1;
            end
        end
        tick();
        ip_valid = 1'b0;
        ip       = 1'b0;
    endtask

    task automatic feed_vec(input logic [63:0] v, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            feed_bit(v[i], 1'b1);
            if (gaps) feed_bit(1'b0, 1'b0);
        end
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort    = 1'b0;
        m_active = 0;
        m_busy   = 0;
        m_done   = 0;
    endtask

    task automatic end_check(input string name);
        @(negedge clk);
        #1;
        check({name, "_done"}, done, m_done);
        check({name, "_busy"}, busy, m_busy);
        check({name, "_match_cnt"}, match_cnt, m_mcnt);
        check({name, "_bit_cnt"}, bit_cnt, m_bitn & 16'hffff);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic model_reset();
        m_pat = PAT_DEF;
        m_ovl = 1;
        m_win = 0;
        m_max = 0;
        m_bits.delete();
        m_since  = 0;
        m_bitn   = 0;
        m_mcnt   = 0;
        m_active = 0;
        m_busy   = 0;
        m_done   = 0;
        exp_q.delete();
    endtask

    task automatic reset_check(input string name);
        @(negedge clk);
        #1;
        check({name, "_op"}, op, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_match_cnt"}, match_cnt, 0);
        check({name, "_bit_cnt"}, bit_cnt, 0);
        check({name, "_err"}, err, 0);
    endtask

    initial begin
        logic [L-1:0] p;
        bit o, b, v;
        int w, mx, k;

        rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
        cfg_win = '0; cfg_max = '0; start = 1'b0; abort = 1'b0;
        ip = 1'b0; ip_valid = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b1;
        reset_check("reset");

        cfg_write(PAT_DEF, 1, 7, 0);
        begin_session();
        feed_vec(64'b1010011, 7, 0);
        end_check("default_win7");

        cfg_write(7'b1010101, 1, 0, 0);
        begin_session();
        feed_vec(64'b10101010101, 11, 0);
        end_check("overlap");
        do_abort();
        end_check("overlap_abort");

        cfg_write(7'b1010101, 0, 0, 0);
        begin_session();
        feed_vec(64'b10101010101, 11, 0);
        end_check("nonoverlap");
        do_abort();

        cfg_write(PAT_DEF, 1, 0, 0);
        begin_session();
        feed_vec(64'b1010011, 7, 1);
        end_check("valid_gaps");
        do_abort();

        cfg_write(7'b1010101, 1, 0, 2);
        begin_session();
        feed_vec(64'b1010101010101, 13, 0);
        end_check("match_limit");

        cfg_write(PAT_DEF, 1, 0, 0);
        begin_session();
        feed_vec(64'b1010, 4, 0);
        do_abort();
        end_check("abort4");

        cfg_write(PAT_DEF, 1, 7, 0);
        begin_session();
        feed_vec(64'b1010011, 7, 0);
        end_check("pre_abort_start");
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        #1;
        check("abort_start_busy", busy, 1);
        check("abort_start_done", done, 0);
        tick();
        @(negedge clk);
        #1;
        check("arm_clear_bit_cnt", bit_cnt, 0);
        check("arm_clear_match_cnt", match_cnt, 0);
        m_active = 1; m_busy = 1; m_done = 0;
        m_bits.delete(); m_since = 0; m_bitn = 0; m_mcnt = 0;
        do_abort();

        check("err_before", err, 0);
        cfg_write(PAT_DEF, 1, 0, 0);
        begin_session();
        feed_vec(64'b101, 3, 0);
        cfg_write(7'b0000000, 0, 5, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        #1;
        check("err_set", err, 1);
        check("err_busy", busy, 1);
        check("err_bit_cnt", bit_cnt, 3);
        feed_vec(64'b0011, 4, 0);
        end_check("err_continue");
        check("err_sticky", err, 1);
        do_abort();

        cfg_write(7'b1111000, 0, 0, 3);
        begin_session();
        feed_vec(64'b110, 3, 0);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        model_reset();
        reset_check("mid_reset");
        begin_session();
        feed_vec(64'b1010011, 7, 0);
        end_check("reset_pattern");
        do_abort();

        for (int s = 0; s < 24; s++) begin
            p  = L'($urandom_range(0, 127));
            o  = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(8, 40));
            mx = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
            cfg_write(p, o, w, mx);
            begin_session();
            k = 0;
            for (int i = 0; i < 48; i++) begin
                v = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 2) != 0) b = p[L - 1 - (k % L)];
                else                           b = 1'($urandom_range(0, 1));
                if (v) k++;
                feed_bit(b, v);
            end
            end_check("random");
            if (m_busy) do_abort();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
